feature_writeback: RTL and testbench

Writer counterpart to the weight loader. It captures a packed vector of NUM `data_len`-bit elements from a layer's compute output and writes it one element per cycle into a single-port result RAM. The write lands in a per-layer region selected by the layer state code `cs`. It sits between the compute array and the feature RAM, and its done pulse lets the layer controller advance `cs`.

---
 rtl/feature_writeback_if.sv | 64 ++++++
 rtl/feature_writeback.sv | 168 ++++++++++++++++
 tb/tb_feature_writeback.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/feature_writeback_if.sv
// ---------------------------------------------------------------------------
// feature_writeback_if
//
// Bundles the signals between the compute array / layer controller and the
// feature writeback block, plus the result-RAM write port it drives.
//
// Signals:
//   cs     4 bits          layer code of the burst, sampled on an accepted start
//   start  1 bit           one-cycle burst request, d valid in the same cycle
//   d      NUM*DW bits     packed element vector, element i = d[i*DW +: DW]
//   busy   1 bit           burst in progress
//   we     1 bit           RAM write enable
//   addr   ADDR_W bits     RAM word address
//   wdata  DW bits         RAM write data
//   done   1 bit           one-cycle pulse after the last write of a burst
//
// Modports:
//   master  compute/controller side: drives cs/start/d, observes the rest
//   slave   writeback block side: the reverse
// ---------------------------------------------------------------------------

`ifndef DATA_LEN
`define DATA_LEN 16
`endif
`ifndef LAYER0
`define LAYER0 4'd1
`endif
`ifndef LAYER1
`define LAYER1 4'd2
`endif
`ifndef LAYER2
`define LAYER2 4'd3
`endif
`ifndef LAYER3
`define LAYER3 4'd4
`endif
`ifndef AFFINE
`define AFFINE 4'd5
`endif

interface feature_writeback_if #(
    parameter int NUM    = 288,
    parameter int ADDR_W = 11,
    parameter int DW     = `DATA_LEN
);
    logic [3:0]        cs;
    logic              start;
    logic [NUM*DW-1:0] d;
    logic              busy;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DW-1:0]     wdata;
    logic              done;

    modport master (
        output cs, start, d,
        input  busy, we, addr, wdata, done
    );

    modport slave (
        input  cs, start, d,
        output busy, we, addr, wdata, done
    );
endinterface

// File: rtl/feature_writeback.sv
// ---------------------------------------------------------------------------
// feature_writeback
//
// Captures a packed vector of NUM elements from a layer's compute output and
// streams it into the single-port feature RAM, one element per cycle, into a
// per-layer region (stride NUM words) chosen by the layer code. A done pulse
// after the last write lets the layer controller advance to the next layer.
//
// Parameters:
//   NUM     elements per burst and region stride in words
//   ADDR_W  RAM address width, must hold 5*NUM-1
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    feature_writeback_if.slave (cs, start, d in; busy, we, addr,
//          wdata, done out, all outputs registered)
//
// Burst timing for a start accepted at edge T:
//   busy high from edge T until the edge after the done pulse,
//   write k visible after edge T+1+k, done after edge T+NUM+1,
//   next start accepted at edge T+NUM+2 at the earliest.
// ---------------------------------------------------------------------------

`ifndef DATA_LEN
`define DATA_LEN 16
`endif
`ifndef LAYER0
`define LAYER0 4'd1
`endif
`ifndef LAYER1
`define LAYER1 4'd2
`endif
`ifndef LAYER2
`define LAYER2 4'd3
`endif
`ifndef LAYER3
`define LAYER3 4'd4
`endif
`ifndef AFFINE
`define AFFINE 4'd5
`endif

module feature_writeback #(
    parameter int NUM    = 288,
    parameter int ADDR_W = 11
) (
    input  logic                clk,
    input  logic                rst_n,
    feature_writeback_if.slave  bus
);

    localparam int DW    = `DATA_LEN;
    localparam int IDX_W = (NUM > 1) ? $clog2(NUM) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DONE
    } state_t;

    state_t              state;
    logic [IDX_W-1:0]    idx;
    logic [ADDR_W-1:0]   base;
    logic                busy_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DW-1:0]       wdata_q;
    logic                done_q;

    // Shadow copy of the input vector so the compute array is free to move on
    // as soon as the start has been accepted.
    logic [DW-1:0]       shadow [NUM];

    logic                cs_legal;
    logic [ADDR_W-1:0]   cs_base;
    logic                accept;
    logic                last_idx;

    // Decode the layer code into its region base; unknown codes are not
    // legal and make the start request a no-op.
    always_comb begin
        cs_legal = 1'b1;
        cs_base  = '0;
        case (bus.cs)
            `LAYER0: cs_base = ADDR_W'(0);
            `LAYER1: cs_base = ADDR_W'(NUM);
            `LAYER2: cs_base = ADDR_W'(2 * NUM);
            `LAYER3: cs_base = ADDR_W'(3 * NUM);
            `AFFINE: cs_base = ADDR_W'(4 * NUM);
            default: cs_legal = 1'b0;
        endcase
    end

    assign accept   = (state == IDLE) && bus.start && cs_legal;
    assign last_idx = (idx == IDX_W'(NUM - 1));

    // Capture the whole vector on an accepted start. The buffer is data only,
    // so it carries no reset; stale contents are never read before a capture.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < NUM; i++) begin
                shadow[i] <= bus.d[i*DW +: DW];
            end
        end
    end

    // Burst sequencer with registered RAM-side outputs. The outputs trail the
    // state by one cycle: the WRITE state issues element idx, which appears on
    // we/addr/wdata after the same edge that advances idx.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            base    <= '0;
            busy_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    we_q   <= 1'b0;
                    done_q <= 1'b0;
                    busy_q <= accept;
                    if (accept) begin
                        base  <= cs_base;
                        idx   <= '0;
                        state <= WRITE;
                    end
                end

                WRITE: begin
                    we_q    <= 1'b1;
                    addr_q  <= base + ADDR_W'(idx);
                    wdata_q <= shadow[idx];
                    if (last_idx) begin
                        idx   <= '0;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end

                DONE: begin
                    we_q   <= 1'b0;
                    done_q <= 1'b1;
                    state  <= IDLE;
                end

                default: begin
                    we_q   <= 1'b0;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.we    = we_q;
    assign bus.addr  = addr_q;
    assign bus.wdata = wdata_q;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_feature_writeback.sv
// ---------------------------------------------------------------------------
// tb_feature_writeback
//
// Scoreboard bench for feature_writeback. Each accepted start pushes the
// expected writes (address, data, cycle), the expected done cycle and the
// expected busy window into queues; a negedge monitor pops and compares
// whatever the DUT presents.
// ---------------------------------------------------------------------------

`ifndef DATA_LEN
`define DATA_LEN 16
`endif
`ifndef LAYER0
`define LAYER0 4'd1
`endif
`ifndef LAYER1
`define LAYER1 4'd2
`endif
`ifndef LAYER2
`define LAYER2 4'd3
`endif
`ifndef LAYER3
`define LAYER3 4'd4
`endif
`ifndef AFFINE
`define AFFINE 4'd5
`endif

module tb_feature_writeback;

    localparam int NUM    = 288;
    localparam int ADDR_W = 11;
    localparam int DW     = `DATA_LEN;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;

    typedef struct {
        int lo;
        int hi;
    } win_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   tests;
    int   fails;

    wr_t  wq[$];
    int   dq[$];
    win_t bq[$];

    feature_writeback_if #(.NUM(NUM), .ADDR_W(ADDR_W), .DW(DW)) bus ();

    feature_writeback #(.NUM(NUM), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Free-running clock and a cycle counter that names each rising edge.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    function automatic int baseOf(input logic [3:0] c);
        case (c)
            `LAYER0: return 0;
            `LAYER1: return NUM;
            `LAYER2: return 2 * NUM;
            `LAYER3: return 3 * NUM;
            `AFFINE: return 4 * NUM;
            default: return -1;
        endcase
    endfunction

    function automatic logic [NUM*DW-1:0] mkVec(input int mode, input int off);
        logic [NUM*DW-1:0] v;
        v = '0;
        for (int i = 0; i < NUM; i++) begin
            if (mode == 0) v[i*DW +: DW] = DW'(off + i);
            else           v[i*DW +: DW] = DW'($urandom);
        end
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic waitUntil(input int target);
        while (cyc < target) step();
    endtask

    // Drive one start pulse sampled at the next edge. If the bench expects it
    // to be taken, the reference model's writes, done and busy window go into
    // the scoreboard, and the accepting edge is returned.
    task automatic applyStimulus(input logic [3:0] c, input logic [NUM*DW-1:0] v,
                                 input bit expect_accept, output int t);
        int b;
        bus.cs    = c;
        bus.d     = v;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        t = cyc;
        if (expect_accept) begin
            b = baseOf(c);
            for (int k = 0; k < NUM; k++) begin
                wq.push_back('{addr: b + k, data: int'(v[k*DW +: DW]), cyc: t + 1 + k});
            end
            dq.push_back(t + NUM + 1);
            bq.push_back('{lo: t, hi: t + NUM + 1});
        end
    endtask

    // Monitor: compares every cycle's outputs against the scoreboard queues.
    always @(negedge clk) begin
        if (rst_n) begin
            bit exp_busy;
            wr_t w;
            while (bq.size() > 0 && bq[0].hi < cyc) void'(bq.pop_front());
            exp_busy = 1'b0;
            foreach (bq[i]) if (cyc >= bq[i].lo && cyc <= bq[i].hi) exp_busy = 1'b1;
            checkOutput("busy", 32'(bus.busy), 32'(exp_busy));

            while (wq.size() > 0 && wq[0].cyc < cyc) begin
                w = wq.pop_front();
                tests++;
                fails++;
                $display("[TB] FAIL missing_write: got none expected addr %0d at cycle %0d",
                         w.addr, w.cyc);
            end
            if (bus.we) begin
                if (wq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_write: got addr %0d expected no write (cycle %0d)",
                             bus.addr, cyc);
                end else begin
                    w = wq.pop_front();
                    checkOutput("write_cycle", 32'(cyc), 32'(w.cyc));
                    checkOutput("addr", 32'(bus.addr), 32'(w.addr));
                    checkOutput("wdata", 32'(bus.wdata), 32'(w.data));
                end
            end

            while (dq.size() > 0 && dq[0] < cyc) begin
                tests++;
                fails++;
                $display("[TB] FAIL missing_done: got none expected done at cycle %0d", dq[0]);
                void'(dq.pop_front());
            end
            if (bus.done) begin
                if (dq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_done: got done=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    checkOutput("done_cycle", 32'(cyc), 32'(dq.pop_front()));
                    checkOutput("we_in_done", 32'(bus.we), 32'd0);
                end
            end
        end
    end

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_busy"},  32'(bus.busy),  32'd0);
        checkOutput({tag, "_we"},    32'(bus.we),    32'd0);
        checkOutput({tag, "_addr"},  32'(bus.addr),  32'd0);
        checkOutput({tag, "_wdata"}, 32'(bus.wdata), 32'd0);
        checkOutput({tag, "_done"},  32'(bus.done),  32'd0);
    endtask

    initial begin
        int t;
        int t2;
        int guard;
        logic [3:0] c;

        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        bus.cs    = 4'd0;
        bus.start = 1'b0;
        bus.d     = '0;

        // Reset state
        repeat (3) step();
        checkIdleOutputs("reset");
        rst_n = 1'b1;

        // LAYER0 ramp burst, start on the first edge out of reset
        applyStimulus(`LAYER0, mkVec(0, 0), 1'b1, t);
        waitUntil(t + NUM + 3);

        // LAYER2 burst with cs/d disturbed mid-burst, an ignored start at
        // write 100 and in the DONE state, then the earliest legal restart
        applyStimulus(`LAYER2, mkVec(0, 16'hA000), 1'b1, t);
        step();
        bus.cs = `LAYER3;
        bus.d  = '0;
        waitUntil(t + 100);
        applyStimulus(`LAYER1, mkVec(1, 0), 1'b0, t2);
        waitUntil(t + NUM);
        applyStimulus(`LAYER3, '0, 1'b0, t2);
        applyStimulus(`LAYER3, mkVec(1, 0), 1'b1, t);
        waitUntil(t + NUM + 3);

        // Illegal layer codes are ignored entirely
        applyStimulus(4'hF, mkVec(1, 0), 1'b0, t);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'($urandom_range(6, 14)), mkVec(1, 0), 1'b0, t);
        end
        repeat (400) step();

        // Reset in the middle of an AFFINE burst
        applyStimulus(`AFFINE, mkVec(1, 0), 1'b1, t);
        waitUntil(t + 51);
        rst_n = 1'b0;
        wq.delete();
        dq.delete();
        bq.delete();
        #1;
        checkIdleOutputs("midreset");
        step();
        step();
        rst_n = 1'b1;
        applyStimulus(`LAYER1, mkVec(1, 0), 1'b1, t);
        waitUntil(t + NUM + 3);

        // Back-to-back bursts at the earliest legal edge
        applyStimulus(`LAYER0, mkVec(1, 0), 1'b1, t);
        waitUntil(t + NUM + 1);
        applyStimulus(`LAYER1, mkVec(1, 0), 1'b1, t2);
        checkOutput("b2b_period", 32'(t2 - t), 32'(NUM + 2));
        waitUntil(t2 + NUM + 3);

        // Random legal bursts with random idle gaps
        for (int n = 0; n < 4; n++) begin
            case ($urandom_range(0, 4))
                0:       c = `LAYER0;
                1:       c = `LAYER1;
                2:       c = `LAYER2;
                3:       c = `LAYER3;
                default: c = `AFFINE;
            endcase
            applyStimulus(c, mkVec(1, 0), 1'b1, t);
            waitUntil(t + NUM + 1 + $urandom_range(0, 5));
        end

        // Drain the scoreboard with a bounded wait
        guard = 0;
        while ((wq.size() > 0 || dq.size() > 0) && guard < 2000) begin
            step();
            guard++;
        end
        if (wq.size() > 0 || dq.size() > 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL drain_timeout: got %0d writes %0d dones pending expected 0",
                     wq.size(), dq.size());
        end
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
